ps2_keyboard_receiver: RTL

//   Input-side counterpart to the 7-segment display driver. Receives scan-code

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_keyboard_receiver_if.sv | 37 +++
 rtl/ps2_input_filter.sv | 64 ++++++
 rtl/ps2_keyboard_receiver.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 keyboard receiver.
//   PS2_DATA_BITS           data bits per PS/2 frame
//   DEFAULT_FILTER_LEN      samples needed to accept a new ps2Clk level
//   DEFAULT_TIMEOUT_CYCLES  max clk cycles between falling edges inside a frame
//   DEFAULT_TIMER_BITS      timeout counter width (2^bits > timeout)
//   ps2_state_e             receiver FSM state encoding
package ps2_pkg;

  localparam int unsigned PS2_DATA_BITS          = 8;
  localparam int unsigned DEFAULT_FILTER_LEN     = 8;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 100000;
  localparam int unsigned DEFAULT_TIMER_BITS     = 17;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_state_e;

  // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                         input logic                     parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_keyboard_receiver_if.sv
// ps2_keyboard_receiver_if: scan-code output bus of the PS/2 receiver.
//   code         received scan code, stable while valid=1
//   valid        code holds an unconsumed byte
//   ready        consumer accepts code when valid && ready
//   parityError  1-cycle pulse, frame dropped for bad odd parity
//   frameError   1-cycle pulse, frame dropped for stop=0 or timeout
//   overrun      1-cycle pulse, good frame dropped because buffer was full
// master = receiver side, slave = consumer side.
interface ps2_keyboard_receiver_if;
  import ps2_pkg::*;

  logic [PS2_DATA_BITS-1:0] code;
  logic                     valid;
  logic                     ready;
  logic                     parityError;
  logic                     frameError;
  logic                     overrun;

  modport master (
    output code,
    output valid,
    output parityError,
    output frameError,
    output overrun,
    input  ready
  );

  modport slave (
    input  code,
    input  valid,
    input  parityError,
    input  frameError,
    input  overrun,
    output ready
  );

endinterface

// File: rtl/ps2_input_filter.sv
// ps2_input_filter: conditions the raw PS/2 pins.
//   clk       in   system clock
//   rst_n     in   asynchronous reset, active-low
//   ps2Clk    in   raw PS/2 clock pin (asynchronous)
//   ps2Data   in   raw PS/2 data pin (asynchronous)
//   fallEvt   out  1-cycle strobe when the filtered clock goes 1->0
//   dataSync  out  synchronised data pin
// The filtered clock changes level only after FILTER_LEN consecutive samples of
// the opposite level; shorter glitches are ignored.
module ps2_input_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2Clk,
  input  logic ps2Data,
  output logic fallEvt,
  output logic dataSync
);

  localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FILTER_LEN - 1);

  logic [1:0]      clk_sync_q;
  logic [1:0]      data_sync_q;
  logic            filt_q, filt_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fall_q, fall_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (clk_sync_q[1] == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      // FILTER_LEN-th consecutive opposite sample: accept the new level
      filt_d = ~filt_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    fall_d = filt_q & ~filt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      cnt_q       <= '0;
      fall_q      <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2Clk};
      data_sync_q <= {data_sync_q[0], ps2Data};
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
      fall_q      <= fall_d;
    end
  end

  assign fallEvt  = fall_q;
  assign dataSync = data_sync_q[1];

endmodule

// File: rtl/ps2_keyboard_receiver.sv
// ps2_keyboard_receiver: device-to-host PS/2 frame receiver.
//   clk      in   system clock
//   rst_n    in   asynchronous reset, active-low
//   ps2Clk   in   raw PS/2 clock pin
//   ps2Data  in   raw PS/2 data pin
//   bus      master modport: code/valid/ready plus error and overrun pulses
// Frame: start(0), 8 data bits LSB first, odd parity, stop(1). Each good byte is
// offered on a one-entry valid/ready buffer one cycle after the stop-bit edge.
module ps2_keyboard_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = DEFAULT_FILTER_LEN,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned TIMER_BITS     = DEFAULT_TIMER_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ps2Clk,
  input  logic                     ps2Data,
  ps2_keyboard_receiver_if.master  bus
);

  localparam int unsigned BitCntW = $clog2(PS2_DATA_BITS);
  localparam logic [BitCntW-1:0]    BitCntLast = BitCntW'(PS2_DATA_BITS - 1);
  localparam logic [TIMER_BITS-1:0] TimerLast  = TIMER_BITS'(TIMEOUT_CYCLES - 1);

  logic fall_evt;
  logic data_sync;

  ps2_input_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_input_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2Clk   (ps2Clk),
    .ps2Data  (ps2Data),
    .fallEvt  (fall_evt),
    .dataSync (data_sync)
  );

  ps2_state_e               state_q, state_d;
  logic [BitCntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [PS2_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                     parity_q, parity_d;
  logic [TIMER_BITS-1:0]    timer_q, timer_d;
  logic [PS2_DATA_BITS-1:0] code_q, code_d;
  logic                     valid_q, valid_d;
  logic                     perr_q, perr_d;
  logic                     ferr_q, ferr_d;
  logic                     ovr_q, ovr_d;
  logic                     deliver;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    parity_d  = parity_q;
    code_d    = code_q;
    valid_d   = valid_q;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    deliver   = 1'b0;

    // Timer measures the gap since the last falling edge inside a frame.
    if (state_q == StIdle || fall_evt) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end

    if (state_q != StIdle && timer_q == TimerLast) begin
      // Stalled frame: drop partial data and resynchronise on the next start bit.
      state_d = StIdle;
      ferr_d  = 1'b1;
      timer_d = '0;
    end else if (fall_evt) begin
      unique case (state_q)
        StIdle: begin
          // A 1 here is a spurious edge, not a start bit.
          if (!data_sync) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
        StData: begin
          shreg_d   = {data_sync, shreg_q[PS2_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BitCntLast) begin
            state_d = StParity;
          end
        end
        StParity: begin
          parity_d = data_sync;
          state_d  = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (!data_sync) begin
            ferr_d = 1'b1;
          end else if (!odd_parity_ok(shreg_q, parity_q)) begin
            perr_d = 1'b1;
          end else begin
            deliver = 1'b1;
          end
        end
      endcase
    end

    // One-entry output buffer; a consume in the same cycle frees room for a new byte.
    if (deliver) begin
      if (!valid_q || bus.ready) begin
        code_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && bus.ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      parity_q  <= 1'b0;
      timer_q   <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      parity_q  <= parity_d;
      timer_q   <= timer_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bus.code        = code_q;
  assign bus.valid       = valid_q;
  assign bus.parityError = perr_q;
  assign bus.frameError  = ferr_q;
  assign bus.overrun     = ovr_q;

endmodule
